// File: rtl/apuf_race_ctrl.sv
// Challenge/launch controller for one arbiter-PUF lane: latches a challenge, fires
// N_EVAL races, synchronises the arbiter decision and returns a majority-voted bit.
module apuf_race_ctrl #(
    parameter int N_STAGES   = 64,
    parameter int SETUP_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int N_EVAL     = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chal_valid,
    output logic                          chal_ready,
    input  logic [N_STAGES-1:0]           chal_in,
    output logic [N_STAGES-1:0]           c_out,
    output logic                          launch,
    input  logic                          arb_in,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_bit,
    output logic [$clog2(N_EVAL+1)-1:0]   resp_ones,
    output logic [2:0]                    dbg_state
);

    localparam int OW   = $clog2(N_EVAL + 1);
    localparam int EW   = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;
    localparam int CMAX = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [EW-1:0] EVAL_LAST   = EW'(N_EVAL - 1);
    localparam logic [OW-1:0] HALF        = OW'(N_EVAL / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        LAUNCH = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic          arb_meta;
    logic          arb_s;
    logic [CW-1:0] cnt;
    logic [EW-1:0] eval;
    logic [OW-1:0] ones;
    logic [OW-1:0] ones_next;

    // Handshakes: a challenge transfers on an edge with chal_valid & chal_ready;
    // a response transfers on an edge with resp_valid & resp_ready, and all resp_*
    // outputs hold until that edge.
    assign ones_next = ones + OW'(arb_s);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arb_meta   <= 1'b0;
            arb_s      <= 1'b0;
            cnt        <= '0;
            eval       <= '0;
            ones       <= '0;
            c_out      <= '0;
            launch     <= 1'b0;
            chal_ready <= 1'b1;
            resp_valid <= 1'b0;
            resp_bit   <= 1'b0;
            resp_ones  <= '0;
        end else begin
            arb_meta <= arb_in;
            arb_s    <= arb_meta;
            case (state)
                IDLE: begin
                    if (chal_valid) begin
                        c_out      <= chal_in;
                        ones       <= '0;
                        eval       <= '0;
                        cnt        <= '0;
                        chal_ready <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt    <= '0;
                        launch <= 1'b1;
                        state  <= LAUNCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LAUNCH: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    // launch stays high through this cycle, dropping as the race ends
                    ones   <= ones_next;
                    eval   <= eval + EW'(1);
                    launch <= 1'b0;
                    if (eval == EVAL_LAST) begin
                        resp_valid <= 1'b1;
                        resp_bit   <= (ones_next > HALF);
                        resp_ones  <= ones_next;
                        state      <= DONE;
                    end else begin
                        state <= SETUP;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_bit   <= 1'b0;
                        resp_ones  <= '0;
                        chal_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apuf_race_ctrl.sv
// Directed bench for apuf_race_ctrl: default lane (u0) plus a single-evaluation,
// short-settle lane (u1) sharing clock and reset.
module tb_apuf_race_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        chal_valid, chal_ready, launch, arb_in;
    logic        resp_valid, resp_ready, resp_bit;
    logic [63:0] chal_in, c_out;
    logic [2:0]  resp_ones, dbg_state;

    logic        chal_valid1, chal_ready1, launch1, arb_in1;
    logic        resp_valid1, resp_ready1, resp_bit1;
    logic [63:0] chal_in1, c_out1;
    logic [0:0]  resp_ones1;
    logic [2:0]  dbg_state1;

    int checks = 0;
    int errors = 0;
    int lat, lbad, sbad;

    apuf_race_ctrl u0 (
        .clk(clk), .rst_n(rst_n),
        .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_in(chal_in),
        .c_out(c_out), .launch(launch), .arb_in(arb_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bit(resp_bit),
        .resp_ones(resp_ones), .dbg_state(dbg_state)
    );

    apuf_race_ctrl #(.N_STAGES(64), .SETUP_CYC(4), .SETTLE_CYC(3), .N_EVAL(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .chal_valid(chal_valid1), .chal_ready(chal_ready1), .chal_in(chal_in1),
        .c_out(c_out1), .launch(launch1), .arb_in(arb_in1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_bit(resp_bit1),
        .resp_ones(resp_ones1), .dbg_state(dbg_state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full challenge on u0; pat[k] is the arbiter value for race k.
    // Expected launch after edge n of the run: high when n%13 >= 4, for n < 65.
    task automatic run0(input logic [63:0] chal, input logic [4:0] pat,
                        output int lat_o, output int lbad_o);
        chal_in    = chal;
        chal_valid = 1'b1;
        arb_in     = pat[0];
        tick();
        chal_valid = 1'b0;
        lat_o  = -1;
        lbad_o = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 5) chal_in = ~chal;
            if (launch !== ((n < 65) && (n % 13 >= 4))) lbad_o++;
            if (resp_valid === 1'b1) begin
                lat_o = n;
                break;
            end
            if ((n % 13 == 0) && (n < 65)) arb_in = pat[n / 13];
        end
    endtask

    task automatic handshake0();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("hs_chal_ready", chal_ready, 1);
        chk("hs_resp_valid", resp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        chal_valid = 0; chal_in = '0; arb_in = 0; resp_ready = 0;
        chal_valid1 = 0; chal_in1 = '0; arb_in1 = 0; resp_ready1 = 0;
        repeat (3) tick();

        chk("rst_chal_ready", chal_ready, 1);
        chk("rst_launch", launch, 0);
        chk("rst_c_out", c_out, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_ones", resp_ones, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_chal_ready1", chal_ready1, 1);
        rst_n = 1'b1;
        tick();

        // constant arb=1: all five races vote 1
        run0(64'hA5A5_0F0F_1234_5678, 5'b11111, lat, lbad);
        chk("t1_latency", lat, 65);
        chk("t1_launch_wave", lbad, 0);
        chk("t1_resp_bit", resp_bit, 1);
        chk("t1_resp_ones", resp_ones, 5);
        chk("t1_c_out", c_out, 64'hA5A5_0F0F_1234_5678);
        chk("t1_launch_done", launch, 0);
        chk("t1_chal_ready", chal_ready, 0);
        chk("t1_state_done", dbg_state, 4);

        // consumer stalls 20 cycles while a new challenge is offered
        chal_valid = 1'b1;
        chal_in    = 64'h1111_2222_3333_4444;
        sbad = 0;
        repeat (20) begin
            tick();
            if (resp_valid !== 1'b1 || resp_bit !== 1'b1 || resp_ones !== 3'd5 ||
                chal_ready !== 1'b0 || launch !== 1'b0) sbad++;
        end
        chal_valid = 1'b0;
        chk("t4_hold", sbad, 0);
        chk("t4_c_out_kept", c_out, 64'hA5A5_0F0F_1234_5678);
        handshake0();
        chk("t4_state_idle", dbg_state, 0);

        // votes 1,0,1,0,0 -> 2 ones
        run0(64'h0123_4567_89AB_CDEF, 5'b00101, lat, lbad);
        chk("t2a_latency", lat, 65);
        chk("t2a_resp_ones", resp_ones, 2);
        chk("t2a_resp_bit", resp_bit, 0);
        chk("t2a_launch_wave", lbad, 0);
        handshake0();

        // votes 1,1,0,1,0 -> 3 ones
        run0(64'hDEAD_BEEF_0000_FFFF, 5'b01011, lat, lbad);
        chk("t2b_latency", lat, 65);
        chk("t2b_resp_ones", resp_ones, 3);
        chk("t2b_resp_bit", resp_bit, 1);
        chk("t2b_c_out", c_out, 64'hDEAD_BEEF_0000_FFFF);
        handshake0();

        // reset asserted during LAUNCH of the second race
        chal_in = 64'hCAFE_F00D_1357_9BDF; chal_valid = 1'b1; arb_in = 1'b1;
        tick();
        chal_valid = 1'b0;
        repeat (19) tick();
        chk("t5_launch_before", launch, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_launch_async", launch, 0);
        chk("t5_c_out_async", c_out, 0);
        chk("t5_resp_valid_async", resp_valid, 0);
        chk("t5_chal_ready_async", chal_ready, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t5_ready_after", chal_ready, 1);
        chk("t5_state_after", dbg_state, 0);
        run0(64'h0F0F_F0F0_AAAA_5555, 5'b11111, lat, lbad);
        chk("t5_latency", lat, 65);
        chk("t5_resp_ones", resp_ones, 5);
        chk("t5_resp_bit", resp_bit, 1);
        chk("t5_launch_wave", lbad, 0);
        handshake0();

        // single evaluation, settle 3: latency 4+3+1 = 8, chal_valid held high
        arb_in1 = 1'b1; chal_in1 = 64'h0000_0000_0000_00C3; chal_valid1 = 1'b1;
        tick();
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (resp_valid1 === 1'b1) begin lat = n; break; end
        end
        chk("t6a_latency", lat, 8);
        chk("t6a_resp_bit", resp_bit1, 1);
        chk("t6a_resp_ones", resp_ones1, 1);
        chk("t6a_c_out", c_out1, 64'h0000_0000_0000_00C3);
        chal_in1 = 64'h0000_0000_0000_003C; arb_in1 = 1'b0;
        repeat (3) tick();
        chk("t6a_held_valid", resp_valid1, 1);
        chk("t6a_c_out_kept", c_out1, 64'h0000_0000_0000_00C3);
        resp_ready1 = 1'b1;
        tick();
        resp_ready1 = 1'b0;
        chk("t6_hs_ready", chal_ready1, 1);
        chk("t6_hs_valid", resp_valid1, 0);
        tick();
        chk("t6b_accepted", chal_ready1, 0);
        chk("t6b_c_out", c_out1, 64'h0000_0000_0000_003C);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            if (resp_valid1 === 1'b1) begin lat = n - 1; break; end
            tick();
        end
        chk("t6b_latency", lat, 8);
        chk("t6b_resp_bit", resp_bit1, 0);
        chk("t6b_resp_ones", resp_ones1, 0);
        chal_valid1 = 1'b0;
        resp_ready1 = 1'b1;
        tick();
        resp_ready1 = 1'b0;
        chk("t6b_hs_ready", chal_ready1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
